// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache-miss fill controller.
package cache_pkg;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  // Aligns a byte address down to the start of its 16-byte block.
  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return {addr[15:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/fill_counter.sv
// 4-bit counter with synchronous clear and increment enable; clear wins.
module fill_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt_q
);

  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache-miss fill controller: issues eight pipelined word reads for the missing
// block, streams returned words into the data array, then writes the tag.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic [15:0] memory_address,
  input  logic        memory_data_valid,
  output logic        write_data_array,
  output logic [2:0]  fill_word,
  output logic        write_tag_array
);

  localparam logic [3:0] BLOCK_WORDS = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] LAST_WORD   = 4'(WORDS_PER_BLOCK - 1);

  fill_state_e state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  issue_cnt, recv_cnt;
  logic        in_fill, issue_inc, recv_inc, fill_done, cnt_clr;
  logic [15:0] req_addr;

  always_comb begin
    in_fill   = (state_q == ST_FILL);
    issue_inc = in_fill && (issue_cnt < BLOCK_WORDS);
    recv_inc  = in_fill && memory_data_valid;
    fill_done = recv_inc && (recv_cnt == LAST_WORD);
    // Counters sit at zero outside a fill and are wiped as the last word lands.
    cnt_clr   = rst || !in_fill || fill_done;
    req_addr  = base_q + {12'd0, issue_cnt[2:0], 1'b0};

    state_d = state_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_detected) begin
          state_d = ST_FILL;
          base_d  = block_base(miss_address);
        end
      end
      ST_FILL: begin
        if (fill_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  fill_counter u_issue_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .inc   (issue_inc),
    .cnt_q (issue_cnt)
  );

  fill_counter u_recv_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .inc   (recv_inc),
    .cnt_q (recv_cnt)
  );

  // Outputs are forced low while reset is held so a held miss cannot stall the pipe.
  always_comb begin
    fsm_busy         = !rst && (in_fill || miss_detected);
    mem_en           = !rst && issue_inc;
    memory_address   = (!rst && issue_inc) ? req_addr : 16'd0;
    write_data_array = !rst && recv_inc;
    fill_word        = (!rst && recv_inc) ? recv_cnt[2:0] : 3'd0;
    write_tag_array  = !rst && fill_done;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a cycle table covering fill, ignored miss and
// back-to-back fill, plus hand sequences for reset, reset mid-fill and latency 1.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'd0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_en, write_data_array, write_tag_array;
  logic [15:0] memory_address;
  logic [2:0]  fill_word;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        miss;
    logic [15:0] maddr;
    logic        valid;
    logic        busy;
    logic        en;
    logic [15:0] addr;
    logic        wda;
    logic [2:0]  fw;
    logic        tag;
  } vec_t;

  vec_t vecs[$];

  cache_fill_fsm #(.WORDS_PER_BLOCK(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic m, input logic [15:0] ma,
                               input logic v);
    rst               = r;
    miss_detected     = m;
    miss_address      = ma;
    memory_data_valid = v;
  endtask

  // Samples on the falling edge, then advances to just after the next rising edge.
  task automatic checkOutput(input string name, input int cyc, input logic busy,
                             input logic en, input logic [15:0] addr, input logic wda,
                             input logic [2:0] fw, input logic tag);
    logic [22:0] act, exp;
    @(negedge clk);
    act = {fsm_busy, mem_en, memory_address, write_data_array, fill_word, write_tag_array};
    exp = {busy, en, addr, wda, fw, tag};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got busy=%b en=%b addr=%h wda=%b fw=%0d tag=%b, want busy=%b en=%b addr=%h wda=%b fw=%0d tag=%b",
               name, cyc, fsm_busy, mem_en, memory_address, write_data_array, fill_word,
               write_tag_array, busy, en, addr, wda, fw, tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic buildTable();
    vec_t r;
    for (int c = 0; c <= 26; c++) begin
      r.rst   = 1'b0;
      r.miss  = (c == 0) || (c == 3) || (c == 13);
      r.maddr = (c == 0) ? 16'h1236 : (c == 3) ? 16'hA000 : (c == 13) ? 16'hFFF0 : 16'h0000;
      r.valid = (c >= 5 && c <= 12) || (c >= 18 && c <= 26);
      r.busy  = (c <= 25);
      r.en    = (c >= 1 && c <= 8) || (c >= 14 && c <= 21);
      r.addr  = 16'h0000;
      if (c >= 1 && c <= 8)   r.addr = 16'h1230 + 16'(2 * (c - 1));
      if (c >= 14 && c <= 21) r.addr = 16'hFFF0 + 16'(2 * (c - 14));
      r.wda   = (c >= 5 && c <= 12) || (c >= 18 && c <= 25);
      r.fw    = 3'd0;
      if (c >= 5 && c <= 12)  r.fw = 3'(c - 5);
      if (c >= 18 && c <= 25) r.fw = 3'(c - 18);
      r.tag   = (c == 12) || (c == 25);
      vecs.push_back(r);
    end
  endtask

  initial begin
    buildTable();
    @(posedge clk);
    #1;

    // Reset held with a miss pending: nothing may be requested or stalled.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 1'b1, 16'h1236, 1'b0);
      checkOutput("reset_hold", c, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    checkOutput("idle_stale_valid", 0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].miss, vecs[i].maddr, vecs[i].valid);
      checkOutput("table", i, vecs[i].busy, vecs[i].en, vecs[i].addr, vecs[i].wda,
                  vecs[i].fw, vecs[i].tag);
    end

    // Reset in cycle 6 of an L=4 fill; later responses must not write anything.
    for (int c = 0; c <= 5; c++) begin
      applyStimulus(1'b0, c == 0, 16'h1236, c == 5);
      checkOutput("rst_mid_pre", c, 1'b1, c >= 1, (c >= 1) ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0,
                  c == 5, 3'd0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
    checkOutput("rst_mid_assert", 6, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
    for (int c = 7; c <= 12; c++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      checkOutput("rst_mid_after", c, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0);
    end

    // Latency-1 fill straight after the aborted one; counters must restart at 0.
    for (int c = 0; c <= 10; c++) begin
      applyStimulus(1'b0, c == 0, 16'h004A, c >= 2 && c <= 9);
      checkOutput("lat1", c, c <= 9, c >= 1 && c <= 8,
                  (c >= 1 && c <= 8) ? 16'h0040 + 16'(2 * (c - 1)) : 16'h0,
                  c >= 2 && c <= 9, (c >= 2 && c <= 9) ? 3'(c - 2) : 3'd0, c == 9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
